// File: rtl/bitbrick_seq_ctrl.sv
// bitbrick_seq_ctrl: time-multiplexes one 2-bit bitbrick to compute a signed/unsigned multiply of up to 8x8
// bits, issuing one slice pair per cycle and accumulating the shifted partial products.
module bitbrick_seq_ctrl #(
   parameter int BB_LAT = 1,
   parameter int ACC_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   input  logic [1:0]       prec_a,
   input  logic [1:0]       prec_b,
   input  logic             signed_a,
   input  logic             signed_b,
   output logic [1:0]       bb_x,
   output logic [1:0]       bb_y,
   output logic             bb_sign_x,
   output logic             bb_sign_y,
   input  logic [5:0]       bb_p,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_product,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   // every tag stage except the last; DRAIN ends once only the last stage may still hold a tag
   localparam logic [BB_LAT-1:0] MID = BB_LAT'((1 << (BB_LAT - 1)) - 1);
   state_t state, state_nx;
   logic [7:0] a_r, b_r;
   logic sa_r, sb_r;
   logic [1:0] la, lb, i, j;
   logic [BB_LAT-1:0] vld;
   logic [BB_LAT-1:0][3:0] sh;
   logic [ACC_W-1:0] acc, pp;
   logic issue, last;
   assign issue = state == ISSUE;
   assign last = (i == la) && (j == lb);
   assign in_ready = state == IDLE;
   assign busy = state != IDLE;
   assign out_valid = state == DONE;
   assign out_product = acc;
   assign bb_x = issue ? a_r[{i, 1'b0} +: 2] : 2'b0;
   assign bb_y = issue ? b_r[{j, 1'b0} +: 2] : 2'b0;
   assign bb_sign_x = issue && sa_r && (i == la);
   assign bb_sign_y = issue && sb_r && (j == lb);
   assign pp = {{(ACC_W - 6){bb_p[5]}}, bb_p} << sh[BB_LAT-1];
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  state_nx = in_valid ? ISSUE : IDLE;
         ISSUE: state_nx = last ? DRAIN : ISSUE;
         DRAIN: state_nx = |(vld & MID) ? DRAIN : DONE;
         DONE:  state_nx = out_ready ? IDLE : DONE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         a_r <= '0;
         b_r <= '0;
         sa_r <= 1'b0;
         sb_r <= 1'b0;
         la <= '0;
         lb <= '0;
         i <= '0;
         j <= '0;
         vld <= '0;
         sh <= '0;
         acc <= '0;
      end else begin
         state <= state_nx;
         vld[0] <= issue;
         sh[0] <= {1'b0, i, 1'b0} + {1'b0, j, 1'b0};
         for (int k = 1; k < BB_LAT; k++) begin
            vld[k] <= vld[k-1];
            sh[k] <= sh[k-1];
         end
         if (state == IDLE && in_valid) begin
            a_r <= a;
            b_r <= b;
            sa_r <= signed_a;
            sb_r <= signed_b;
            la <= (prec_a == 2'd0) ? 2'd0 : (prec_a == 2'd1) ? 2'd1 : 2'd3;
            lb <= (prec_b == 2'd0) ? 2'd0 : (prec_b == 2'd1) ? 2'd1 : 2'd3;
            i <= '0;
            j <= '0;
            acc <= '0;
         end else begin
            if (vld[BB_LAT-1]) acc <= acc + pp;
            if (issue) begin
               i <= (i == la) ? 2'd0 : i + 2'd1;
               if (i == la) j <= j + 2'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_bitbrick_seq_ctrl.sv
// tb_bitbrick_seq_ctrl: drives a BB_LAT=1 and a BB_LAT=3 sequencer with shared stimulus; each has its own
// bitbrick model, and a scoreboard checks issue slices, latency and product against an arithmetic model.
module tb_bitbrick_seq_ctrl;
   logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
   logic [7:0] a = 0, b = 0;
   logic [1:0] prec_a = 0, prec_b = 0;
   logic signed_a = 0, signed_b = 0;
   logic in_ready [2], busy [2], out_valid [2], sx [2], sy [2];
   logic [1:0] bx [2], by [2];
   logic [5:0] bp [2];
   logic [15:0] prod [2];
   logic [5:0] p1, p3 [3];
   typedef struct {logic [15:0] prod; int due;} exp_t;
   typedef struct {logic [5:0] bb; int at;} iss_t;
   exp_t eq [2][$];
   iss_t iq [2][$];
   bit seen [2];
   int cyc = 0, tests = 0, fails = 0, bp_mode = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bitbrick_seq_ctrl #(.BB_LAT(1), .ACC_W(16)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]), .a(a), .b(b),
      .prec_a(prec_a), .prec_b(prec_b), .signed_a(signed_a), .signed_b(signed_b),
      .bb_x(bx[0]), .bb_y(by[0]), .bb_sign_x(sx[0]), .bb_sign_y(sy[0]), .bb_p(bp[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready), .out_product(prod[0]), .busy(busy[0]));
   bitbrick_seq_ctrl #(.BB_LAT(3), .ACC_W(16)) dut3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]), .a(a), .b(b),
      .prec_a(prec_a), .prec_b(prec_b), .signed_a(signed_a), .signed_b(signed_b),
      .bb_x(bx[1]), .bb_y(by[1]), .bb_sign_x(sx[1]), .bb_sign_y(sy[1]), .bb_p(bp[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready), .out_product(prod[1]), .busy(busy[1]));

   function automatic logic [5:0] bbf(input logic [1:0] x, input logic [1:0] y, input logic tx, input logic ty);
      int vx = (tx && x[1]) ? int'(x) - 4 : int'(x);
      int vy = (ty && y[1]) ? int'(y) - 4 : int'(y);
      return 6'(vx * vy);
   endfunction

   always @(posedge clk) begin
      p1 <= bbf(bx[0], by[0], sx[0], sy[0]);
      p3[0] <= bbf(bx[1], by[1], sx[1], sy[1]);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign bp[0] = p1;
   assign bp[1] = p3[2];

   function automatic int wid(input logic [1:0] p);
      return (p == 2'd0) ? 2 : (p == 2'd1) ? 4 : 8;
   endfunction

   function automatic int oval(input logic [7:0] v, input logic [1:0] p, input logic s);
      int w = wid(p);
      int r = int'(v) & ((1 << w) - 1);
      if (s && r >= (1 << (w - 1))) r -= (1 << w);
      return r;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (in_ready[0] && in_ready[1]) return;
      end
      chk("idle_timeout", 0, 1);
   endtask

   task automatic issue(input logic [7:0] ta, input logic [7:0] tbv, input logic [1:0] pa, input logic [1:0] pb,
                        input logic tsa, input logic tsb);
      int na, nb, k;
      logic [15:0] pr;
      logic [5:0] e;
      wait_idle();
      a = ta; b = tbv; prec_a = pa; prec_b = pb; signed_a = tsa; signed_b = tsb; in_valid = 1;
      na = wid(pa) / 2;
      nb = wid(pb) / 2;
      pr = 16'(oval(ta, pa, tsa) * oval(tbv, pb, tsb));
      k = 0;
      for (int jj = 0; jj < nb; jj++)
         for (int ii = 0; ii < na; ii++) begin
            e = {2'(ta >> (2 * ii)), 2'(tbv >> (2 * jj)), tsa && ii == na - 1, tsb && jj == nb - 1};
            for (int d = 0; d < 2; d++) iq[d].push_back('{e, cyc + 1 + k});
            k++;
         end
      eq[0].push_back('{pr, cyc + na * nb + 2});
      eq[1].push_back('{pr, cyc + na * nb + 4});
      @(posedge clk);
      #1 in_valid = 0;
      a = 8'($urandom); b = 8'($urandom); prec_a = 2'($urandom); prec_b = 2'($urandom);
      signed_a = 1'($urandom); signed_b = 1'($urandom);
   endtask

   always @(negedge clk) if (!reset) for (int d = 0; d < 2; d++) begin
      if (iq[d].size() != 0 && iq[d][0].at == cyc) begin
         chk("issue_slices", {bx[d], by[d], sx[d], sy[d]}, iq[d][0].bb);
         void'(iq[d].pop_front());
      end
      if (out_valid[d]) begin
         if (eq[d].size() == 0) chk("spurious_out_valid", 1, 0);
         else begin
            if (!seen[d]) begin
               chk("out_latency", cyc, eq[d][0].due);
               seen[d] <= 1'b1;
            end
            chk("out_product", prod[d], eq[d][0].prod);
            chk("busy_in_done", busy[d], 1);
            if (out_ready) begin
               void'(eq[d].pop_front());
               seen[d] <= 1'b0;
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1 if (bp_mode == 0) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #2;
      for (int d = 0; d < 2; d++) begin
         chk("rst_in_ready", in_ready[d], 1);
         chk("rst_out_valid", out_valid[d], 0);
         chk("rst_busy", busy[d], 0);
         chk("rst_product", prod[d], 0);
         chk("rst_bb", {bx[d], by[d], sx[d], sy[d]}, 0);
      end
      @(posedge clk);
      #1 reset = 0;
      issue(8'h03, 8'h03, 2'd0, 2'd0, 0, 0);
      issue(8'h80, 8'h7F, 2'd2, 2'd2, 1, 1);
      issue(8'hFF, 8'hFF, 2'd2, 2'd2, 1, 0);
      issue(8'hFF, 8'hFF, 2'd2, 2'd2, 0, 0);
      issue(8'hA9, 8'd200, 2'd1, 2'd2, 1, 0);
      issue(8'hFE, 8'h81, 2'd3, 2'd0, 1, 1);
      for (int r = 0; r < 40; r++)
         issue(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      // backpressure: hold DONE, pulse in_valid, then release
      wait_idle();
      bp_mode = 1;
      out_ready = 0;
      issue(8'h5A, 8'h3C, 2'd1, 2'd1, 0, 0);
      for (int k = 0; k < 100 && !out_valid[1]; k++) @(negedge clk);
      chk("bp_reached_done", out_valid[1], 1);
      for (int k = 0; k < 5; k++) begin
         for (int d = 0; d < 2; d++) begin
            chk("bp_out_valid", out_valid[d], 1);
            chk("bp_in_ready", in_ready[d], 0);
         end
         in_valid = 1; a = 8'hFF; b = 8'hFF; prec_a = 2'd2; prec_b = 2'd2;
         @(negedge clk);
      end
      in_valid = 0;
      @(posedge clk);
      #1 out_ready = 1;
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("bp_release_in_ready", in_ready[d], 1);
         chk("bp_release_out_valid", out_valid[d], 0);
      end
      bp_mode = 0;
      // reset in cycle T+5 of an 8x8 operation
      issue(8'h80, 8'h7F, 2'd2, 2'd2, 1, 1);
      repeat (4) @(posedge clk);
      #1 reset = 1;
      for (int d = 0; d < 2; d++) begin
         eq[d].delete();
         iq[d].delete();
         seen[d] = 1'b0;
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("midrst_out_valid", out_valid[d], 0);
         chk("midrst_bb", {bx[d], by[d], sx[d], sy[d]}, 0);
         chk("midrst_in_ready", in_ready[d], 1);
         chk("midrst_busy", busy[d], 0);
      end
      @(posedge clk);
      #1 reset = 0;
      issue(8'h03, 8'h02, 2'd0, 2'd0, 0, 0);
      issue(8'h80, 8'h7F, 2'd2, 2'd2, 1, 1);
      wait_idle();
      chk("queues_drained", eq[0].size() + eq[1].size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
